// File: rtl/shift_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_normalizer_if
//  Brief    : Valid/ready handshake bundle for the iterative normalizer.
//             master = producer/consumer side, slave = normalizer side.
//  Revision : 1.0
// ============================================================================
interface shift_normalizer_if #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic             dir;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic [SW-1:0]    shift_amt;
   logic             zero;

   modport master (
      output in_valid, data_in, dir, out_ready,
      input  in_ready, out_valid, data_out, shift_amt, zero
   );

   modport slave (
      input  in_valid, data_in, dir, out_ready,
      output in_ready, out_valid, data_out, shift_amt, zero
   );
endinterface
`default_nettype wire

// File: rtl/shift_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_normalizer
//  Brief    : Iterative normalizer. Shifts one bit per clock until the first
//             set bit reaches the MSB (dir=0) or LSB (dir=1); returns the
//             normalized word, the shift count and a zero-input flag.
//  Revision : 1.0
// ============================================================================
module shift_normalizer #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  wire logic          Clock,
   input  wire logic          Reset_n,
   shift_normalizer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] shifted;
   logic             dir_r;
   logic [SW-1:0]    cnt;
   logic [WIDTH-1:0] data_out_r;
   logic [SW-1:0]    shift_amt_r;
   logic             zero_r;

   logic             accept;
   logic             in_zero;
   logic             in_target;
   logic             sh_target;

   // A word is only ever accepted in IDLE; in_ready already encodes that.
   assign accept    = bus.in_valid && bus.in_ready;
   assign in_zero   = (bus.data_in == '0);
   assign in_target = bus.dir ? bus.data_in[0] : bus.data_in[WIDTH-1];
   assign shifted   = dir_r ? (work >> 1) : (work << 1);
   assign sh_target = dir_r ? shifted[0] : shifted[WIDTH-1];

   assign bus.data_out  = data_out_r;
   assign bus.shift_amt = shift_amt_r;
   assign bus.zero      = zero_r;

   // State register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; in_ready is held low during reset.
   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = Reset_n;
            if (accept) begin
               state_next = (in_zero || in_target) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (sh_target) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Working register, count and result registers; results load only when
   // a word completes, so they hold their value across the handshake.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         work        <= '0;
         dir_r       <= 1'b0;
         cnt         <= '0;
         data_out_r  <= '0;
         shift_amt_r <= '0;
         zero_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work  <= bus.data_in;
                  dir_r <= bus.dir;
                  cnt   <= '0;
                  if (in_zero || in_target) begin
                     data_out_r  <= bus.data_in;
                     shift_amt_r <= '0;
                     zero_r      <= in_zero;
                  end
               end
            end
            SHIFT: begin
               // Input is nonzero here, so the target is reached within
               // WIDTH-1 shifts and the count cannot wrap.
               work <= shifted;
               cnt  <= cnt + SW'(1);
               if (sh_target) begin
                  data_out_r  <= shifted;
                  shift_amt_r <= cnt + SW'(1);
                  zero_r      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
